// File: rtl/gtwizard_drp_pkg.sv
// Shared definitions for the GTXE2_COMMON DRP initiator.
//   DRP_ADDR_W / DRP_DATA_W : DRP port widths of the common block
//   FULL_MASK               : write mask that selects a plain (non-RMW) write
//   drp_state_e             : initiator FSM states
//   rmw_merge               : bit-select merge used for read-modify-write
package gtwizard_drp_pkg;

  localparam int DRP_ADDR_W = 8;
  localparam int DRP_DATA_W = 16;

  localparam logic [DRP_DATA_W-1:0] FULL_MASK = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_EN   = 3'd1,
    RD_WAIT = 3'd2,
    WR_EN   = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } drp_state_e;

  // Bits where mask is 1 come from new_data, the rest keep old_data.
  function automatic logic [DRP_DATA_W-1:0] rmw_merge(
    input logic [DRP_DATA_W-1:0] old_data,
    input logic [DRP_DATA_W-1:0] new_data,
    input logic [DRP_DATA_W-1:0] mask
  );
    return (old_data & ~mask) | (new_data & mask);
  endfunction

endpackage

// File: rtl/gtwizard_common_drp.sv
// DRP initiator for the GTXE2_COMMON (QPLL) block.
// Accepts single-register read, write and masked read-modify-write requests
// and returns exactly one response per accepted request. Every DRP access is
// guarded by a bounded wait so a missing DRPRDY cannot hang the initiator.
//
// Ports
//   DRPCLK_IN, RESET_IN        : clock (same as common block DRPCLK), sync active-high reset
//   REQ_VALID_IN/REQ_READY_OUT : request handshake
//   REQ_WRITE_IN, REQ_ADDR_IN, REQ_DATA_IN, REQ_MASK_IN : request fields
//   RSP_VALID_OUT, RSP_DATA_OUT, RSP_ERR_OUT : one-cycle response pulse, data, timeout flag
//   DRPADDR_OUT, DRPDI_OUT, DRPEN_OUT, DRPWE_OUT : DRP command to the common block
//   DRPDO_IN, DRPRDY_IN        : DRP read data / completion from the common block
//   DBG_STATE_OUT              : current FSM state, for observation only
//
// Handshake: a request transfers on the rising edge where REQ_VALID_IN and
// REQ_READY_OUT are both high; REQ_READY_OUT is high only in IDLE (and never
// while RESET_IN is high). The request fields need only be valid on that edge.
// RSP_VALID_OUT is a single-cycle pulse with no back-pressure; RSP_DATA_OUT
// and RSP_ERR_OUT hold their value until the next response.
module gtwizard_common_drp
  import gtwizard_drp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  DRPCLK_IN,
  input  logic                  RESET_IN,
  input  logic                  REQ_VALID_IN,
  output logic                  REQ_READY_OUT,
  input  logic                  REQ_WRITE_IN,
  input  logic [DRP_ADDR_W-1:0] REQ_ADDR_IN,
  input  logic [DRP_DATA_W-1:0] REQ_DATA_IN,
  input  logic [DRP_DATA_W-1:0] REQ_MASK_IN,
  output logic                  RSP_VALID_OUT,
  output logic [DRP_DATA_W-1:0] RSP_DATA_OUT,
  output logic                  RSP_ERR_OUT,
  output logic [DRP_ADDR_W-1:0] DRPADDR_OUT,
  output logic [DRP_DATA_W-1:0] DRPDI_OUT,
  output logic                  DRPEN_OUT,
  output logic                  DRPWE_OUT,
  input  logic [DRP_DATA_W-1:0] DRPDO_IN,
  input  logic                  DRPRDY_IN,
  output drp_state_e            DBG_STATE_OUT
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count value during the last permitted wait cycle (count starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  drp_state_e state, state_nxt;

  logic                  write_q;
  logic [DRP_ADDR_W-1:0] addr_q;
  logic [DRP_DATA_W-1:0] data_q;
  logic [DRP_DATA_W-1:0] mask_q;
  logic [DRP_DATA_W-1:0] di_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DRP_DATA_W-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic req_ready;
  logic accept;
  logic timed_out;
  logic rmw_pending;
  logic in_wait;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge DRPCLK_IN) begin
    if (RESET_IN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = (state == IDLE) && !RESET_IN;
    accept      = REQ_VALID_IN && req_ready;
    timed_out   = (cnt_q == CNT_LAST);
    // A write with a partial mask still needs its write phase after the read.
    rmw_pending = write_q && (mask_q != '0);
    in_wait     = (state == RD_WAIT) || (state == WR_WAIT);
    case (state)
      IDLE: begin
        if (accept) begin
          // Full-mask writes need no read; everything else starts with a read.
          if (REQ_WRITE_IN && (REQ_MASK_IN == FULL_MASK)) state_nxt = WR_EN;
          else                                            state_nxt = RD_EN;
        end
      end
      RD_EN:   state_nxt = RD_WAIT;
      RD_WAIT: begin
        // Ready wins over an expiring count in the same cycle.
        if (DRPRDY_IN)      state_nxt = rmw_pending ? WR_EN : DONE;
        else if (timed_out) state_nxt = DONE;
      end
      WR_EN:   state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (DRPRDY_IN || timed_out) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge DRPCLK_IN) begin
    if (RESET_IN) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      di_q       <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= REQ_WRITE_IN;
        addr_q  <= REQ_ADDR_IN;
        data_q  <= REQ_DATA_IN;
        mask_q  <= REQ_MASK_IN;
        di_q    <= REQ_DATA_IN;
      end

      // Counter runs only inside a wait state and restarts for each access.
      if (in_wait) cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      else         cnt_q <= '0;

      if (state == RD_WAIT) begin
        if (DRPRDY_IN) begin
          if (rmw_pending) begin
            di_q <= rmw_merge(DRPDO_IN, data_q, mask_q);
          end else begin
            rsp_data_q <= DRPDO_IN;
            rsp_err_q  <= 1'b0;
          end
        end else if (timed_out) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end

      if (state == WR_WAIT) begin
        if (DRPRDY_IN) begin
          rsp_data_q <= di_q;
          rsp_err_q  <= 1'b0;
        end else if (timed_out) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // Address and write data come straight from registers that only change on
  // acceptance or between the read and write phase, so they are stable from
  // each DRPEN pulse until its DRPRDY or timeout.
  assign REQ_READY_OUT = req_ready;
  assign DRPEN_OUT     = (state == RD_EN) || (state == WR_EN);
  assign DRPWE_OUT     = (state == WR_EN);
  assign DRPADDR_OUT   = addr_q;
  assign DRPDI_OUT     = di_q;
  assign RSP_VALID_OUT = (state == DONE);
  assign RSP_DATA_OUT  = rsp_data_q;
  assign RSP_ERR_OUT   = rsp_err_q;
  assign DBG_STATE_OUT = state;

endmodule

// File: tb/tb_gtwizard_common_drp.sv
// Bench for gtwizard_common_drp: a DRP responder with its own register file,
// a transaction-level model that predicts every DRPEN pulse and response from
// the request and the planned responder latencies, a per-cycle compare
// process, directed cases with literal expectations, then random traffic.
module tb_gtwizard_common_drp;
  import gtwizard_drp_pkg::*;

  localparam int T = 64;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_data = '0;
  logic [15:0] req_mask = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  drp_addr;
  logic [15:0] drp_di;
  logic        drp_en;
  logic        drp_we;
  logic [15:0] drp_do = '0;
  logic        drp_rdy = 1'b0;
  drp_state_e  dbg_state;

  gtwizard_common_drp #(.TIMEOUT_CYCLES(T)) dut (
    .DRPCLK_IN     (clk),
    .RESET_IN      (rst),
    .REQ_VALID_IN  (req_valid),
    .REQ_READY_OUT (req_ready),
    .REQ_WRITE_IN  (req_write),
    .REQ_ADDR_IN   (req_addr),
    .REQ_DATA_IN   (req_data),
    .REQ_MASK_IN   (req_mask),
    .RSP_VALID_OUT (rsp_valid),
    .RSP_DATA_OUT  (rsp_data),
    .RSP_ERR_OUT   (rsp_err),
    .DRPADDR_OUT   (drp_addr),
    .DRPDI_OUT     (drp_di),
    .DRPEN_OUT     (drp_en),
    .DRPWE_OUT     (drp_we),
    .DRPDO_IN      (drp_do),
    .DRPRDY_IN     (drp_rdy),
    .DBG_STATE_OUT (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard state
  int total = 0;
  int bad   = 0;

  typedef struct {int c; logic we; logic [7:0] addr; logic [15:0] di;} en_t;
  typedef struct {int c; logic [15:0] data; logic err;} rsp_t;

  en_t  exp_en_q[$];
  rsp_t exp_rsp_q[$];
  int   lat_q[$];        // responder latency per DRPEN, 0 = never answer
  int   busy_start = 0;
  int   busy_until = -1;
  bit   cmp_on = 1'b0;

  logic [15:0] model_regs [256];
  logic [15:0] mem [256];

  int          en_seen = 0, we_seen = 0, rsp_seen = 0;
  int          last_rsp_c = 0;
  logic [15:0] last_rsp_data = '0;
  logic        last_rsp_err = 1'b0;
  logic [15:0] last_di = '0;
  int          inject_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [15:0] v);
    mem[a] = v;
    model_regs[a] = v;
  endtask

  // ---------------------------------------------------------------- DRP responder
  bit          pend = 1'b0;
  int          pend_c = 0;
  logic        pend_we = 1'b0;
  logic [7:0]  pend_addr = '0;
  logic [15:0] pend_di = '0;

  initial begin
    int lat;
    forever begin
      @(posedge clk); #1;
      if (pend && cyc == pend_c) begin
        drp_rdy = 1'b1;
        if (pend_we) begin
          mem[pend_addr] = pend_di;
          drp_do = 16'($urandom);
        end else begin
          drp_do = mem[pend_addr];
        end
        pend = 1'b0;
      end else if (cyc == inject_cyc) begin
        drp_rdy = 1'b1;
        drp_do  = 16'hDEAD;
      end else begin
        drp_rdy = 1'b0;
        drp_do  = 16'($urandom);
      end
      @(negedge clk);
      if (drp_en === 1'b1) begin
        lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        pend = (lat > 0);
        pend_c = cyc + lat;
        pend_we = drp_we;
        pend_addr = drp_addr;
        pend_di = drp_di;
      end
    end
  end

  // ---------------------------------------------------------------- compare process
  initial begin
    bit exp_en, exp_rsp, exp_ready;
    en_t  e;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        exp_en    = (exp_en_q.size() > 0) && (exp_en_q[0].c == cyc);
        exp_rsp   = (exp_rsp_q.size() > 0) && (exp_rsp_q[0].c == cyc);
        exp_ready = !rst && !(cyc >= busy_start && cyc <= busy_until);
        chk("drpen", 32'(drp_en), 32'(exp_en));
        if (exp_en) begin
          e = exp_en_q.pop_front();
          chk("drpwe", 32'(drp_we), 32'(e.we));
          chk("drpaddr", 32'(drp_addr), 32'(e.addr));
          if (e.we) chk("drpdi", 32'(drp_di), 32'(e.di));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp) begin
          r = exp_rsp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(r.data));
          chk("rsp_err", 32'(rsp_err), 32'(r.err));
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
      end
      if (drp_en === 1'b1) en_seen++;
      if (drp_en === 1'b1 && drp_we === 1'b1) begin
        we_seen++;
        last_di = drp_di;
      end
      if (rsp_valid === 1'b1) begin
        rsp_seen++;
        last_rsp_c = cyc;
        last_rsp_data = rsp_data;
        last_rsp_err = rsp_err;
      end
    end
  end

  // ---------------------------------------------------------------- driver + model
  // Phase timing from the protocol: EN at cycle en_c, ready at en_c+lat when
  // 1<=lat<=T, else the wait gives up after T cycles; the next step follows
  // one cycle after the phase ends.
  function automatic bit lat_ok(input int lat);
    return (lat >= 1) && (lat <= T);
  endfunction

  function automatic int phase_end(input int en_c, input int lat);
    return lat_ok(lat) ? en_c + lat : en_c + T;
  endfunction

  task automatic do_req(input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic [15:0] m, input int k, input int mlat, output int acc);
    int guard, en1, en2, rc;
    bit full, rmw;
    logic [15:0] old, nv;
    rsp_t r;
    guard = 0;
    while (cyc <= busy_until && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) chk("idle_wait_bound", 32'd1, 32'd0);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_mask  = m;
    acc  = cyc;
    full = w && (m == 16'hFFFF);
    rmw  = w && (m != 16'h0000) && !full;
    en1  = acc + 1;
    if (full) begin
      exp_en_q.push_back('{c: en1, we: 1'b1, addr: a, di: d});
      lat_q.push_back(mlat);
      rc = phase_end(en1, mlat) + 1;
      if (lat_ok(mlat)) model_regs[a] = d;
      r = '{c: rc, data: lat_ok(mlat) ? d : 16'h0, err: !lat_ok(mlat)};
    end else begin
      exp_en_q.push_back('{c: en1, we: 1'b0, addr: a, di: 16'h0});
      lat_q.push_back(k);
      if (!lat_ok(k)) begin
        rc = phase_end(en1, k) + 1;
        r = '{c: rc, data: 16'h0, err: 1'b1};
      end else begin
        old = model_regs[a];
        if (rmw) begin
          nv  = (old & ~m) | (d & m);
          en2 = phase_end(en1, k) + 1;
          exp_en_q.push_back('{c: en2, we: 1'b1, addr: a, di: nv});
          lat_q.push_back(mlat);
          rc = phase_end(en2, mlat) + 1;
          if (lat_ok(mlat)) model_regs[a] = nv;
          r = '{c: rc, data: lat_ok(mlat) ? nv : 16'h0, err: !lat_ok(mlat)};
        end else begin
          rc = phase_end(en1, k) + 1;
          r = '{c: rc, data: old, err: 1'b0};
        end
      end
    end
    exp_rsp_q.push_back(r);
    busy_start = acc + 1;
    busy_until = rc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 8'($urandom);
    req_data  = 16'($urandom);
    req_mask  = 16'($urandom);
  endtask

  task automatic wait_until(input int c);
    int guard;
    guard = 0;
    while (cyc <= c && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) chk("wait_bound", 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_drpaddr"}, 32'(drp_addr), 32'd0);
    chk({tag, "_drpdi"}, 32'(drp_di), 32'd0);
    chk({tag, "_drpen"}, 32'(drp_en), 32'd0);
    chk({tag, "_drpwe"}, 32'(drp_we), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  function automatic int pick_lat();
    int p;
    p = $urandom_range(0, 99);
    if (p < 4) return 0;
    if (p < 6) return T;
    return $urandom_range(1, 6);
  endfunction

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main sequence
  initial begin
    int a, e0, w0, r0;
    logic [15:0] m;
    for (int i = 0; i < 256; i++) set_reg(8'(i), 16'($urandom));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_on = 1'b1;

    // Read, ready 3 cycles after DRPEN
    set_reg(8'h36, 16'hA5C3);
    e0 = en_seen; w0 = we_seen;
    do_req(1'b0, 8'h36, 16'h7777, 16'hFFFF, 3, 0, a);
    wait_until(busy_until);
    chk("t1_rsp_cyc", 32'(last_rsp_c - a), 32'd5);
    chk("t1_data", 32'(last_rsp_data), 32'hA5C3);
    chk("t1_err", 32'(last_rsp_err), 32'd0);
    chk("t1_en_cnt", 32'(en_seen - e0), 32'd1);
    chk("t1_we_cnt", 32'(we_seen - w0), 32'd0);

    // Full-mask write
    e0 = en_seen; w0 = we_seen;
    do_req(1'b1, 8'h32, 16'h1234, 16'hFFFF, 0, 2, a);
    wait_until(busy_until);
    chk("t2_rsp_cyc", 32'(last_rsp_c - a), 32'd4);
    chk("t2_data", 32'(last_rsp_data), 32'h1234);
    chk("t2_en_cnt", 32'(en_seen - e0), 32'd1);
    chk("t2_we_cnt", 32'(we_seen - w0), 32'd1);
    chk("t2_di", 32'(last_di), 32'h1234);
    chk("t2_mem", 32'(mem[8'h32]), 32'h1234);

    // Read-modify-write
    set_reg(8'h33, 16'hFF00);
    e0 = en_seen; w0 = we_seen;
    do_req(1'b1, 8'h33, 16'h00AA, 16'h00F0, 2, 1, a);
    wait_until(busy_until);
    chk("t3_rsp_cyc", 32'(last_rsp_c - a), 32'd6);
    chk("t3_data", 32'(last_rsp_data), 32'hFFA0);
    chk("t3_en_cnt", 32'(en_seen - e0), 32'd2);
    chk("t3_we_cnt", 32'(we_seen - w0), 32'd1);
    chk("t3_di", 32'(last_di), 32'hFFA0);
    chk("t3_mem", 32'(mem[8'h33]), 32'hFFA0);

    // Timeout, then a stale ready, then a normal read
    do_req(1'b0, 8'h40, 16'h0, 16'h0, 0, 0, a);
    inject_cyc = a + 70;
    wait_until(a + 71);
    chk("t4_rsp_cyc", 32'(last_rsp_c - a), 32'd66);
    chk("t4_err", 32'(last_rsp_err), 32'd1);
    chk("t4_data", 32'(last_rsp_data), 32'd0);
    set_reg(8'h41, 16'h5A5A);
    do_req(1'b0, 8'h41, 16'h0, 16'h0, 2, 0, a);
    wait_until(busy_until);
    chk("t4_next_data", 32'(last_rsp_data), 32'h5A5A);
    chk("t4_next_err", 32'(last_rsp_err), 32'd0);

    // Ready on the expiry cycle
    set_reg(8'h42, 16'h0F0F);
    do_req(1'b0, 8'h42, 16'h0, 16'h0, T, 0, a);
    wait_until(busy_until);
    chk("t5_rsp_cyc", 32'(last_rsp_c - a), 32'd66);
    chk("t5_err", 32'(last_rsp_err), 32'd0);
    chk("t5_data", 32'(last_rsp_data), 32'h0F0F);

    // Zero-mask write is a read
    set_reg(8'h43, 16'hC0DE);
    e0 = en_seen; w0 = we_seen;
    do_req(1'b1, 8'h43, 16'hFFFF, 16'h0000, 1, 0, a);
    wait_until(busy_until);
    chk("t6_en_cnt", 32'(en_seen - e0), 32'd1);
    chk("t6_we_cnt", 32'(we_seen - w0), 32'd0);
    chk("t6_data", 32'(last_rsp_data), 32'hC0DE);
    chk("t6_mem", 32'(mem[8'h43]), 32'hC0DE);

    // Reset during RD_WAIT with a late ready afterwards
    r0 = rsp_seen;
    do_req(1'b0, 8'h44, 16'h0, 16'h0, 10, 0, a);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_en_q.delete();
    exp_rsp_q.delete();
    lat_q.delete();
    busy_until = -1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("t7_in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t7_ready_after", 32'(req_ready), 32'd1);
    wait_until(a + 13);
    chk("t7_no_rsp", 32'(rsp_seen - r0), 32'd0);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       m = 16'hFFFF;
        1:       m = 16'h0000;
        default: m = 16'($urandom);
      endcase
      do_req(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom), m,
             pick_lat(), pick_lat(), a);
    end
    wait_until(busy_until + 2);
    chk("queues_drained", 32'(exp_rsp_q.size() + exp_en_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gtwizard_common_drp.md
# gtwizard_common_drp

DRP initiator for the GTXE2_COMMON block in the transceiver wrapper; drives the QPLL common block's DRPADDR/DRPDI/DRPEN/DRPWE and consumes DRPDO/DRPRDY. It accepts single-register read, write and masked read-modify-write requests from control logic and returns one response per request. A bounded wait guards against a missing DRPRDY. It sits between the SATA link control logic and the common block's DRP port, which is currently tied off.

## Interface
- TIMEOUT_CYCLES, 64, maximum number of wait cycles after a DRPEN pulse with no DRPRDY before the access is abandoned; legal range ≥1.
- DRPCLK_IN  in  1  sole clock; the same clock that drives the common block's DRPCLK.
- RESET_IN  in  1  reset; synchronous, active-high.
- REQ_VALID_IN  in  1  request valid.
- REQ_READY_OUT  out  1  request accepted when high together with REQ_VALID_IN.
- REQ_WRITE_IN  in  1  0 = read, 1 = write or RMW.
- REQ_ADDR_IN  in  8  DRP register address.
- REQ_DATA_IN  in  16  write data.
- REQ_MASK_IN  in  16  write bit-enable; 1 = take bit from REQ_DATA_IN.
- RSP_VALID_OUT  out  1  one-cycle response pulse.
- RSP_DATA_OUT  out  16  read value or final written value; held until the next response.
- RSP_ERR_OUT  out  1  timeout flag; valid with RSP_VALID_OUT.
- DRPADDR_OUT  out  8  to DRPADDR.
- DRPDI_OUT  out  16  to DRPDI.
- DRPEN_OUT  out  1  to DRPEN.
- DRPWE_OUT  out  1  to DRPWE.
- DRPDO_IN  in  16  from DRPDO.
- DRPRDY_IN  in  1  from DRPRDY.

## Operation
- FSM states: IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, DONE.
- REQ_READY_OUT = (state == IDLE). A request is captured at the edge where valid & ready; address, data, mask and write are registered.
- Read (WRITE=0), or write with MASK=16'h0000: IDLE→RD_EN→RD_WAIT→DONE. RSP_DATA = DRPDO captured on DRPRDY. No write is issued.
- Write with MASK=16'hFFFF: IDLE→WR_EN→WR_WAIT→DONE. DRPDI = REQ_DATA. RSP_DATA = written value.
- Write, any other mask: RD_EN→RD_WAIT→WR_EN→WR_WAIT→DONE. New value = (DRPDO & ~MASK) | (DATA & MASK). RSP_DATA = new value.
- RD_EN/WR_EN: DRPEN_OUT=1 for exactly that one cycle; DRPWE_OUT=1 only in WR_EN. DRPADDR_OUT/DRPDI_OUT are stable from the EN cycle until the matching DRPRDY or timeout.
- WAIT states: the counter increments each cycle. DRPRDY_IN=1 exits the state. If the count reaches TIMEOUT_CYCLES without DRPRDY, the FSM goes to DONE with ERR=1 and RSP_DATA=0. A read-phase timeout skips the write phase.
- DRPRDY in the same cycle the counter expires: the ready takes priority and ERR=0.
- DRPRDY_IN outside the WAIT states is ignored, including a stale ready after a timeout or reset.
- DONE: RSP_VALID_OUT=1 for one cycle, then IDLE.
- Reset (at any state): state=IDLE, counter=0, and every output is 0 (REQ_READY_OUT goes to 1 in the first cycle after reset deasserts). An in-flight access is dropped with no response.

## Timing
- The request is accepted at edge A. DRPEN is high in cycle A+1.
- Single access with DRPRDY in cycle A+1+k (k≥1): RSP_VALID is high in cycle A+2+k.
- RMW: read DRPRDY at A+1+k, write DRPEN at A+2+k, write DRPRDY at A+2+k+m, RSP_VALID at A+3+k+m.
- Timeout: with no DRPRDY in cycles A+2 … A+1+TIMEOUT_CYCLES, RSP_VALID (ERR=1) is high in cycle A+2+TIMEOUT_CYCLES.
- DRPRDY in the EN cycle itself is not sampled; the protocol guarantees at least one cycle of latency.
- Minimum request-to-request spacing: 4 cycles (single access with k=1).
- Counter width is clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.

## Structure
- Shared package gtwizard_drp_pkg holds DRP_ADDR_W=8, DRP_DATA_W=16, the FSM state enum, and FULL_MASK=16'hFFFF.
- Single flat module; no sub-module is warranted. The timeout counter is inline.

## Test plan
- Read addr 8'h36, responder returns 16'hA5C3 with DRPRDY 3 cycles after DRPEN → one DRPEN, DRPWE=0, RSP_VALID at A+5, RSP_DATA=16'hA5C3, ERR=0.
- Write addr 8'h32, data 16'h1234, mask 16'hFFFF → no read; DRPEN & DRPWE in cycle A+1 with DRPDI=16'h1234; RSP_DATA=16'h1234.
- RMW addr 8'h33, register holds 16'hFF00, data 16'h00AA, mask 16'h00F0 → read, then write DRPDI=16'hFFA0; RSP_DATA=16'hFFA0; exactly two DRPEN pulses.
- No DRPRDY, TIMEOUT_CYCLES=64 → RSP_VALID at A+66 with ERR=1 and RSP_DATA=0. A DRPRDY injected at A+70 has no effect, and the next request completes normally.
- DRPRDY on the exact expiry cycle (A+65) → ERR=0 and data captured. Mask 16'h0000 write → read only, no DRPWE.
- RESET_IN asserted in RD_WAIT, then a late DRPRDY → all outputs 0 during reset, no RSP_VALID, REQ_READY_OUT=1 after release.
